// File: rtl/mem_controller.sv
// Multi-channel arbiter between LSU consumers and external memory channels.
// Each channel owns at most one consumer at a time and relays one read or write transaction.
module mem_controller #(
    parameter int unsigned ADDR_BITS     = 8,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned NUM_CONSUMERS = 4,
    parameter int unsigned NUM_CHANNELS  = 1,
    parameter bit          WRITE_ENABLE  = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,

    input  logic [NUM_CONSUMERS-1:0] consumer_read_valid,
    input  logic [ADDR_BITS-1:0]     consumer_read_address [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_read_ready,
    output logic [DATA_BITS-1:0]     consumer_read_data    [NUM_CONSUMERS],

    input  logic [NUM_CONSUMERS-1:0] consumer_write_valid,
    input  logic [ADDR_BITS-1:0]     consumer_write_address [NUM_CONSUMERS],
    input  logic [DATA_BITS-1:0]     consumer_write_data    [NUM_CONSUMERS],
    output logic [NUM_CONSUMERS-1:0] consumer_write_ready,

    output logic [NUM_CHANNELS-1:0]  mem_read_valid,
    output logic [ADDR_BITS-1:0]     mem_read_address [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_read_ready,
    input  logic [DATA_BITS-1:0]     mem_read_data    [NUM_CHANNELS],

    output logic [NUM_CHANNELS-1:0]  mem_write_valid,
    output logic [ADDR_BITS-1:0]     mem_write_address [NUM_CHANNELS],
    output logic [DATA_BITS-1:0]     mem_write_data    [NUM_CHANNELS],
    input  logic [NUM_CHANNELS-1:0]  mem_write_ready
);

    localparam int unsigned IdxW = (NUM_CONSUMERS > 1) ? $clog2(NUM_CONSUMERS) : 1;

    typedef enum logic [2:0] {
        StIdle,
        StReadWaiting,
        StWriteWaiting,
        StReadRelaying,
        StWriteRelaying
    } state_e;

    state_e                   state_q  [NUM_CHANNELS];
    logic [IdxW-1:0]          owner_q  [NUM_CHANNELS];
    logic [ADDR_BITS-1:0]     addr_q   [NUM_CHANNELS];
    logic [DATA_BITS-1:0]     wdata_q  [NUM_CHANNELS];
    logic [NUM_CHANNELS-1:0]  mrv_q;
    logic [NUM_CHANNELS-1:0]  mwv_q;
    logic [NUM_CONSUMERS-1:0] claim_q;
    logic [NUM_CONSUMERS-1:0] crr_q;
    logic [NUM_CONSUMERS-1:0] cwr_q;
    logic [DATA_BITS-1:0]     crd_q    [NUM_CONSUMERS];

    logic [NUM_CHANNELS-1:0]  grant_vld;
    logic [NUM_CHANNELS-1:0]  grant_wr;
    logic [IdxW-1:0]          grant_idx [NUM_CHANNELS];
    logic [NUM_CONSUMERS-1:0] taken;

    // Lower channels pick first; each pick is marked taken so later channels skip it.
    always_comb begin
        taken = claim_q;
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            grant_vld[ch] = 1'b0;
            grant_wr[ch]  = 1'b0;
            grant_idx[ch] = '0;
            if (state_q[ch] == StIdle) begin
                for (int c = 0; c < NUM_CONSUMERS; c++) begin
                    if (!grant_vld[ch] && !taken[c]) begin
                        if (consumer_read_valid[c]) begin
                            grant_vld[ch] = 1'b1;
                            grant_idx[ch] = IdxW'(c);
                        end else if (WRITE_ENABLE && consumer_write_valid[c]) begin
                            grant_vld[ch] = 1'b1;
                            grant_wr[ch]  = 1'b1;
                            grant_idx[ch] = IdxW'(c);
                        end
                    end
                end
                if (grant_vld[ch]) begin
                    taken[grant_idx[ch]] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                state_q[ch] <= StIdle;
                owner_q[ch] <= '0;
                addr_q[ch]  <= '0;
                wdata_q[ch] <= '0;
            end
            for (int c = 0; c < NUM_CONSUMERS; c++) begin
                crd_q[c] <= '0;
            end
            mrv_q   <= '0;
            mwv_q   <= '0;
            claim_q <= '0;
            crr_q   <= '0;
            cwr_q   <= '0;
        end else begin
            for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
                unique case (state_q[ch])
                    StIdle: begin
                        if (grant_vld[ch]) begin
                            owner_q[ch]             <= grant_idx[ch];
                            claim_q[grant_idx[ch]]  <= 1'b1;
                            if (grant_wr[ch]) begin
                                addr_q[ch]  <= consumer_write_address[grant_idx[ch]];
                                wdata_q[ch] <= consumer_write_data[grant_idx[ch]];
                                mwv_q[ch]   <= 1'b1;
                                state_q[ch] <= StWriteWaiting;
                            end else begin
                                addr_q[ch]  <= consumer_read_address[grant_idx[ch]];
                                mrv_q[ch]   <= 1'b1;
                                state_q[ch] <= StReadWaiting;
                            end
                        end
                    end
                    StReadWaiting: begin
                        if (mem_read_ready[ch]) begin
                            mrv_q[ch]             <= 1'b0;
                            crr_q[owner_q[ch]]    <= 1'b1;
                            crd_q[owner_q[ch]]    <= mem_read_data[ch];
                            state_q[ch]           <= StReadRelaying;
                        end
                    end
                    StWriteWaiting: begin
                        if (mem_write_ready[ch]) begin
                            mwv_q[ch]             <= 1'b0;
                            cwr_q[owner_q[ch]]    <= 1'b1;
                            state_q[ch]           <= StWriteRelaying;
                        end
                    end
                    StReadRelaying: begin
                        if (!consumer_read_valid[owner_q[ch]]) begin
                            crr_q[owner_q[ch]]    <= 1'b0;
                            crd_q[owner_q[ch]]    <= '0;
                            claim_q[owner_q[ch]]  <= 1'b0;
                            state_q[ch]           <= StIdle;
                        end
                    end
                    StWriteRelaying: begin
                        if (!consumer_write_valid[owner_q[ch]]) begin
                            cwr_q[owner_q[ch]]    <= 1'b0;
                            claim_q[owner_q[ch]]  <= 1'b0;
                            state_q[ch]           <= StIdle;
                        end
                    end
                    default: state_q[ch] <= StIdle;
                endcase
            end
        end
    end

    assign consumer_read_ready  = crr_q;
    assign consumer_read_data   = crd_q;
    assign consumer_write_ready = WRITE_ENABLE ? cwr_q : '0;
    assign mem_read_valid       = mrv_q;
    assign mem_write_valid      = WRITE_ENABLE ? mwv_q : '0;

    always_comb begin
        for (int ch = 0; ch < NUM_CHANNELS; ch++) begin
            mem_read_address[ch]  = addr_q[ch];
            mem_write_address[ch] = WRITE_ENABLE ? addr_q[ch] : '0;
            mem_write_data[ch]    = WRITE_ENABLE ? wdata_q[ch] : '0;
        end
    end

endmodule

// File: tb/tb_mem_controller.sv
// Directed bench for mem_controller: one single-channel and one dual-channel instance.
module tb_mem_controller;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Single-channel instance
    logic [3:0] a_crv, a_crr, a_cwv, a_cwr;
    logic [7:0] a_cra [4];
    logic [7:0] a_crd [4];
    logic [7:0] a_cwa [4];
    logic [7:0] a_cwd [4];
    logic [0:0] a_mrv, a_mrr, a_mwv, a_mwr;
    logic [7:0] a_mra [1];
    logic [7:0] a_mrd [1];
    logic [7:0] a_mwa [1];
    logic [7:0] a_mwd [1];

    // Dual-channel instance
    logic [3:0] b_crv, b_crr, b_cwv, b_cwr;
    logic [7:0] b_cra [4];
    logic [7:0] b_crd [4];
    logic [7:0] b_cwa [4];
    logic [7:0] b_cwd [4];
    logic [1:0] b_mrv, b_mrr, b_mwv, b_mwr;
    logic [7:0] b_mra [2];
    logic [7:0] b_mrd [2];
    logic [7:0] b_mwa [2];
    logic [7:0] b_mwd [2];

    mem_controller #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(1), .WRITE_ENABLE(1'b1)
    ) dut1 (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (a_crv),
        .consumer_read_address  (a_cra),
        .consumer_read_ready    (a_crr),
        .consumer_read_data     (a_crd),
        .consumer_write_valid   (a_cwv),
        .consumer_write_address (a_cwa),
        .consumer_write_data    (a_cwd),
        .consumer_write_ready   (a_cwr),
        .mem_read_valid         (a_mrv),
        .mem_read_address       (a_mra),
        .mem_read_ready         (a_mrr),
        .mem_read_data          (a_mrd),
        .mem_write_valid        (a_mwv),
        .mem_write_address      (a_mwa),
        .mem_write_data         (a_mwd),
        .mem_write_ready        (a_mwr)
    );

    mem_controller #(
        .ADDR_BITS(8), .DATA_BITS(8), .NUM_CONSUMERS(4), .NUM_CHANNELS(2), .WRITE_ENABLE(1'b1)
    ) dut2 (
        .clk                    (clk),
        .reset                  (reset),
        .consumer_read_valid    (b_crv),
        .consumer_read_address  (b_cra),
        .consumer_read_ready    (b_crr),
        .consumer_read_data     (b_crd),
        .consumer_write_valid   (b_cwv),
        .consumer_write_address (b_cwa),
        .consumer_write_data    (b_cwd),
        .consumer_write_ready   (b_cwr),
        .mem_read_valid         (b_mrv),
        .mem_read_address       (b_mra),
        .mem_read_ready         (b_mrr),
        .mem_read_data          (b_mrd),
        .mem_write_valid        (b_mwv),
        .mem_write_address      (b_mwa),
        .mem_write_data         (b_mwd),
        .mem_write_ready        (b_mwr)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change and outputs are sampled on the falling edge.
    task automatic step();
        @(negedge clk);
    endtask

    int ord [3] = '{0, 1, 3};
    int c;

    initial begin
        reset = 1'b1;
        a_crv = '0; a_cwv = '0; a_mrr = '0; a_mwr = '0;
        b_crv = '0; b_cwv = '0; b_mrr = '0; b_mwr = '0;
        for (int i = 0; i < 4; i++) begin
            a_cra[i] = '0; a_cwa[i] = '0; a_cwd[i] = '0;
            b_cra[i] = '0; b_cwa[i] = '0; b_cwd[i] = '0;
        end
        a_mrd[0] = '0;
        b_mrd[0] = '0; b_mrd[1] = '0;
        step(); step();
        chk("reset_mrv", {31'd0, a_mrv}, 32'd0);
        chk("reset_crr", {28'd0, a_crr}, 32'd0);
        chk("reset_mra", {24'd0, a_mra[0]}, 32'd0);
        chk("reset_b_mrv", {30'd0, b_mrv}, 32'd0);
        reset = 1'b0;
        step();

        // Single read from consumer 2
        a_crv[2] = 1'b1; a_cra[2] = 8'h10;
        step();
        chk("rd_mrv", {31'd0, a_mrv}, 32'd1);
        chk("rd_mra", {24'd0, a_mra[0]}, 32'h10);
        chk("rd_crr_early", {28'd0, a_crr}, 32'd0);
        a_mrr = 1'b1; a_mrd[0] = 8'h5A;
        step();
        chk("rd_mrv_drop", {31'd0, a_mrv}, 32'd0);
        chk("rd_crr", {28'd0, a_crr}, 32'b0100);
        chk("rd_crd", {24'd0, a_crd[2]}, 32'h5A);
        a_mrr = 1'b0; a_mrd[0] = 8'h00;
        step();
        chk("rd_hold", {28'd0, a_crr}, 32'b0100);
        a_crv[2] = 1'b0;
        step();
        chk("rd_release", {28'd0, a_crr}, 32'd0);
        step();
        chk("rd_idle", {31'd0, a_mrv}, 32'd0);

        // Contention on one channel: 0, 1, 3 served in order
        a_cra[0] = 8'h01; a_cra[1] = 8'h02; a_cra[3] = 8'h04;
        a_crv = 4'b1011;
        for (int k = 0; k < 3; k++) begin
            c = ord[k];
            step();
            chk("ct_mrv", {31'd0, a_mrv}, 32'd1);
            chk("ct_mra", {24'd0, a_mra[0]}, (c == 3) ? 32'h04 : 32'(c + 1));
            chk("ct_crr_idle", {28'd0, a_crr}, 32'd0);
            a_mrr = 1'b1; a_mrd[0] = 8'(8'hA0 + k);
            step();
            chk("ct_crr", {28'd0, a_crr}, 32'(1 << c));
            chk("ct_crd", {24'd0, a_crd[c]}, 32'(8'hA0 + k));
            a_mrr = 1'b0;
            a_crv[c] = 1'b0;
            step();
            chk("ct_release", {28'd0, a_crr}, 32'd0);
        end

        // Read and write on the same consumer: read first
        a_crv[1] = 1'b1; a_cra[1] = 8'h11;
        a_cwv[1] = 1'b1; a_cwa[1] = 8'h20; a_cwd[1] = 8'h33;
        step();
        chk("rw_mrv", {31'd0, a_mrv}, 32'd1);
        chk("rw_mra", {24'd0, a_mra[0]}, 32'h11);
        chk("rw_mwv_early", {31'd0, a_mwv}, 32'd0);
        a_mrr = 1'b1; a_mrd[0] = 8'h77;
        step();
        chk("rw_crr", {28'd0, a_crr}, 32'b0010);
        chk("rw_crd", {24'd0, a_crd[1]}, 32'h77);
        chk("rw_cwr_early", {28'd0, a_cwr}, 32'd0);
        a_mrr = 1'b0; a_crv[1] = 1'b0;
        step();
        chk("rw_rd_release", {28'd0, a_crr}, 32'd0);
        step();
        chk("rw_mwv", {31'd0, a_mwv}, 32'd1);
        chk("rw_mwa", {24'd0, a_mwa[0]}, 32'h20);
        chk("rw_mwd", {24'd0, a_mwd[0]}, 32'h33);
        chk("rw_mrv_off", {31'd0, a_mrv}, 32'd0);
        a_mwr = 1'b1;
        step();
        chk("rw_mwv_drop", {31'd0, a_mwv}, 32'd0);
        chk("rw_cwr", {28'd0, a_cwr}, 32'b0010);
        a_mwr = 1'b0; a_cwv[1] = 1'b0;
        step();
        chk("rw_wr_release", {28'd0, a_cwr}, 32'd0);

        // Memory stall for 10 cycles
        a_crv[0] = 1'b1; a_cra[0] = 8'h44;
        step();
        for (int k = 0; k < 10; k++) begin
            chk("stall_hold", {19'd0, a_mrv, a_mra[0], a_crr}, {19'd0, 1'b1, 8'h44, 4'h0});
            step();
        end
        chk("stall_still", {19'd0, a_mrv, a_mra[0], a_crr}, {19'd0, 1'b1, 8'h44, 4'h0});
        a_mrr = 1'b1; a_mrd[0] = 8'h99;
        step();
        chk("stall_crr", {28'd0, a_crr}, 32'b0001);
        chk("stall_crd", {24'd0, a_crd[0]}, 32'h99);
        a_mrr = 1'b0; a_crv[0] = 1'b0;
        step();
        chk("stall_release", {28'd0, a_crr}, 32'd0);

        // Reset during READ_WAITING, then the same request completes
        a_crv[3] = 1'b1; a_cra[3] = 8'h55;
        step();
        chk("rst_pre_mrv", {31'd0, a_mrv}, 32'd1);
        reset = 1'b1; a_mrr = 1'b1; a_mrd[0] = 8'hEE;
        step();
        chk("rst_mrv", {31'd0, a_mrv}, 32'd0);
        chk("rst_crr", {28'd0, a_crr}, 32'd0);
        chk("rst_mra", {24'd0, a_mra[0]}, 32'd0);
        chk("rst_crd", {24'd0, a_crd[3]}, 32'd0);
        reset = 1'b0; a_mrr = 1'b0;
        step();
        chk("rst_fresh_mrv", {31'd0, a_mrv}, 32'd1);
        chk("rst_fresh_mra", {24'd0, a_mra[0]}, 32'h55);
        a_mrr = 1'b1; a_mrd[0] = 8'h3C;
        step();
        chk("rst_fresh_crr", {28'd0, a_crr}, 32'b1000);
        chk("rst_fresh_crd", {24'd0, a_crd[3]}, 32'h3C);
        a_mrr = 1'b0; a_crv[3] = 1'b0;
        step();
        chk("rst_fresh_release", {28'd0, a_crr}, 32'd0);

        // Two channels, four simultaneous reads
        for (int i = 0; i < 4; i++) b_cra[i] = 8'(8'hB0 + i);
        b_crv = 4'hF;
        step();
        chk("dual_mrv", {30'd0, b_mrv}, 32'b11);
        chk("dual_mra0", {24'd0, b_mra[0]}, 32'hB0);
        chk("dual_mra1", {24'd0, b_mra[1]}, 32'hB1);
        b_mrr = 2'b11; b_mrd[0] = 8'hC0; b_mrd[1] = 8'hC1;
        step();
        chk("dual_crr", {28'd0, b_crr}, 32'b0011);
        chk("dual_crd0", {24'd0, b_crd[0]}, 32'hC0);
        chk("dual_crd1", {24'd0, b_crd[1]}, 32'hC1);
        b_mrr = 2'b00; b_crv = 4'b1100;
        step();
        chk("dual_release", {28'd0, b_crr}, 32'd0);
        step();
        chk("dual2_mrv", {30'd0, b_mrv}, 32'b11);
        chk("dual2_mra0", {24'd0, b_mra[0]}, 32'hB2);
        chk("dual2_mra1", {24'd0, b_mra[1]}, 32'hB3);
        b_mrr = 2'b11; b_mrd[0] = 8'hD2; b_mrd[1] = 8'hD3;
        step();
        chk("dual2_crr", {28'd0, b_crr}, 32'b1100);
        chk("dual2_crd2", {24'd0, b_crd[2]}, 32'hD2);
        chk("dual2_crd3", {24'd0, b_crd[3]}, 32'hD3);
        b_mrr = 2'b00; b_crv = 4'b0000;
        step();
        chk("dual2_release", {28'd0, b_crr}, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
